sensor_conditioner: RTL and testbench
=====================================

# sensor_conditioner

Input-side front end for the automatic irrigation controller: synchronizes and debounces the raw field signals (tank level probes, soil/air humidity switches, temperature switch, display-select switch) and publishes clean, glitch-free levels to the combinational irrigation, level/alarm and display logic. The three tank-level probes are republished as one atomic group, so a rising or falling water surface never shows the downstream error decoder a transient illegal combination (e.g. H=1, M=0). Sits between the board pins and the top-level irrigation controller.

## Interface
- DEB_CYCLES, 50000, consecutive stable clock cycles required to accept a new input value (1 ms at 50 MHz); legal range 2..2^20
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state immediately
- raw_h, raw_m, raw_l  in  1 each  raw tank-level probes (high/medium/low), asynchronous to clk
- raw_us, raw_ua, raw_t, raw_sd  in  1 each  raw soil-humidity, air-humidity, temperature and display-select switches, asynchronous
- H, M, L  out  1 each  published level group
- Us, Ua, T, Sd  out  1 each  debounced switch values
- valid  out  1  high once the startup settling window has elapsed; downstream treats outputs as meaningless while low
- chg  out  1  one-cycle pulse on any cycle in which any of the seven published outputs changes

## Operation
- Reset: all synchronizer flops, debounced registers, counters and outputs = 0; valid = 0; chg = 0.
- Per channel (7 identical instances): 2-flop synchronizer -> sync; debounced register deb; counter cnt of width $clog2(DEB_CYCLES).
  - sync == deb: cnt <= 0.
  - sync != deb and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - sync != deb and cnt == DEB_CYCLES-1: deb <= sync, cnt <= 0.
  - Any bounce (sync returns to deb before terminal count) discards progress; no partial credit.
- Switch outputs Us, Ua, T, Sd are driven directly from their deb registers.
- Level group: published register {H,M,L}. Group FSM, states STABLE and SETTLING:
  - STABLE: if any level channel has cnt != 0 or its deb differs from the published value -> SETTLING.
  - SETTLING: when all three level counters are 0 in the same cycle, load {H,M,L} <= {deb_h,deb_m,deb_l} and go to STABLE. While SETTLING, published H/M/L hold their old values.
  - A level channel that keeps bouncing holds the group in SETTLING indefinitely; the published value stays at the last coherent snapshot.
- valid: startup counter counts DEB_CYCLES+2 cycles after reset release, then sets valid = 1 and stops; valid stays high until the next reset.
- chg = 1 in exactly the cycle after a published output register changes (registered compare of old vs new); multiple simultaneous changes produce a single pulse.

## Timing
- Switch channels: raw edge sampled at edge k -> output changes at edge k+1+DEB_CYCLES (2 synchronizer + DEB_CYCLES-1 counting, with the final count in the same cycle as the deb update).
- Level channels: one extra cycle (group load) -> published at edge k+2+DEB_CYCLES if the other two level channels are quiet.
- chg: one cycle after the published output changes.
- Raw pulses shorter than DEB_CYCLES cycles (after synchronization) never reach any output.
- Reset asserted mid-count: all progress is lost; outputs return to 0 asynchronously.

## Structure
- Shared package: DEB_CYCLES default constant, group-FSM state enum (STABLE, SETTLING).
- Sub-module debounce_channel (synchronizer + counter + deb register; exports deb and a cnt_zero flag), instantiated 7 times; the group FSM, the valid timer and the chg logic live in the top of sensor_conditioner.

## Test plan
- DEB_CYCLES=4; reset then hold all raw inputs at 0 -> valid rises exactly 6 cycles after reset release; all outputs 0; chg never pulses.
- raw_us 0->1 held -> Us = 1 exactly 5 cycles after the sampling edge; chg pulses once, one cycle later.
- raw_ua glitch high for 3 cycles, then low -> Ua stays 0; chg never pulses.
- raw_l rises, then raw_m rises 2 cycles later -> {H,M,L} goes directly 000 -> 011 in a single update; 001 is never published; one chg pulse.
- raw_h toggles every 2 cycles for 40 cycles, with M = L = 1 stable -> {H,M,L} holds 011 throughout; after toggling stops at 1, 111 is published 6 cycles after the last edge.
- Assert rst mid-count on raw_t, 3 cycles into debounce -> T, valid and chg go to 0 immediately; after release, a T transition requires the full DEB_CYCLES again.

Source files
------------

// File: rtl/sensor_conditioner_pkg.sv
// Shared constants and types for the sensor input conditioner: debounce
// window default, channel bit positions and the level-group FSM states.
package sensor_conditioner_pkg;

  // 1 ms at 50 MHz
  localparam int DEB_CYCLES_DEFAULT = 50000;

  localparam int NUM_CH = 7;

  // Bit positions of each channel inside the packed channel vectors
  localparam int CH_H  = 6;
  localparam int CH_M  = 5;
  localparam int CH_L  = 4;
  localparam int CH_US = 3;
  localparam int CH_UA = 2;
  localparam int CH_T  = 1;
  localparam int CH_SD = 0;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } grp_state_e;

  // Width of a counter that must reach max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Board-side raw inputs and the cleaned outputs handed to the irrigation logic.
interface sensor_conditioner_if;
  import sensor_conditioner_pkg::*;

  logic       raw_h;
  logic       raw_m;
  logic       raw_l;
  logic       raw_us;
  logic       raw_ua;
  logic       raw_t;
  logic       raw_sd;

  logic       H;
  logic       M;
  logic       L;
  logic       Us;
  logic       Ua;
  logic       T;
  logic       Sd;
  logic       valid;
  logic       chg;
  grp_state_e grp_state;

  // valid is a level qualifier, not a handshake: there is no ready, and
  // consumers treat every output as meaningless while valid is low. chg is a
  // single-cycle strobe that follows any change of the seven published levels.
  modport master (
    output raw_h, raw_m, raw_l, raw_us, raw_ua, raw_t, raw_sd,
    input  H, M, L, Us, Ua, T, Sd, valid, chg, grp_state
  );

  modport slave (
    input  raw_h, raw_m, raw_l, raw_us, raw_ua, raw_t, raw_sd,
    output H, M, L, Us, Ua, T, Sd, valid, chg, grp_state
  );

endinterface

// File: rtl/sensor_conditioner_debounce_channel.sv
// One raw input: two-flop synchronizer, stability counter and debounced level.
// A new level is accepted only after DEB_CYCLES consecutive differing samples.
module sensor_conditioner_debounce_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic cnt_zero
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any return to the accepted level throws away all progress
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the seven field inputs, republishes the three tank probes as one
// coherent snapshot, and flags startup settling and output changes.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_conditioner_if.slave  bus
);

  localparam int VW = cnt_width(DEB_CYCLES + 1);
  localparam logic [VW-1:0] VALID_LAST = VW'(DEB_CYCLES + 1);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] deb_vec;
  logic [NUM_CH-1:0] zero_vec;

  assign raw_vec = {bus.raw_h, bus.raw_m, bus.raw_l,
                    bus.raw_us, bus.raw_ua, bus.raw_t, bus.raw_sd};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_conditioner_debounce_channel #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce_channel (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_vec[i]),
      .deb      (deb_vec[i]),
      .cnt_zero (zero_vec[i])
    );
  end

  // Level group: publish {H,M,L} only when all three probes are quiet together
  logic [2:0] lvl_deb;
  logic       lvl_quiet;
  logic [2:0] pub_lvl;
  logic       load_lvl;
  grp_state_e state;
  grp_state_e state_nxt;

  assign lvl_deb   = deb_vec[CH_H:CH_L];
  assign lvl_quiet = &zero_vec[CH_H:CH_L];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STABLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_lvl  = 1'b0;
    case (state)
      STABLE: begin
        if (!lvl_quiet || (lvl_deb != pub_lvl)) begin
          state_nxt = SETTLING;
        end
      end
      SETTLING: begin
        if (lvl_quiet) begin
          load_lvl  = 1'b1;
          state_nxt = STABLE;
        end
      end
      default: begin
        state_nxt = STABLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pub_lvl <= 3'b000;
    end else if (load_lvl) begin
      pub_lvl <= lvl_deb;
    end
  end

  // Startup window: valid rises DEB_CYCLES+2 cycles after reset release
  logic [VW-1:0] su_cnt;
  logic          valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      su_cnt  <= '0;
      valid_q <= 1'b0;
    end else if (!valid_q) begin
      if (su_cnt == VALID_LAST) begin
        valid_q <= 1'b1;
      end else begin
        su_cnt <= su_cnt + VW'(1);
      end
    end
  end

  // Change strobe compares the published outputs against last cycle's copy
  logic [NUM_CH-1:0] out_vec;
  logic [NUM_CH-1:0] out_prev;
  logic              chg_q;

  assign out_vec = {pub_lvl, deb_vec[CH_US:CH_SD]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_prev <= '0;
      chg_q    <= 1'b0;
    end else begin
      out_prev <= out_vec;
      chg_q    <= (out_vec != out_prev);
    end
  end

  assign bus.H         = pub_lvl[2];
  assign bus.M         = pub_lvl[1];
  assign bus.L         = pub_lvl[0];
  assign bus.Us        = deb_vec[CH_US];
  assign bus.Ua        = deb_vec[CH_UA];
  assign bus.T         = deb_vec[CH_T];
  assign bus.Sd        = deb_vec[CH_SD];
  assign bus.valid     = valid_q;
  assign bus.chg       = chg_q;
  assign bus.grp_state = state;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner with a short debounce window: directed
// scenarios plus randomized raw activity checked against a history-based model.
module tb_sensor_conditioner;
  import sensor_conditioner_pkg::*;

  localparam int DEB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sensor_conditioner_if bus();

  logic [6:0] raw = '0;
  assign bus.raw_h  = raw[6];
  assign bus.raw_m  = raw[5];
  assign bus.raw_l  = raw[4];
  assign bus.raw_us = raw[3];
  assign bus.raw_ua = raw[2];
  assign bus.raw_t  = raw[1];
  assign bus.raw_sd = raw[0];

  sensor_conditioner #(.DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [6:0] dut_out = {bus.H, bus.M, bus.L, bus.Us, bus.Ua, bus.T, bus.Sd};
  wire [2:0] dut_lvl = {bus.H, bus.M, bus.L};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // A channel accepts value v once the last DEB synchronized samples were all v.
  // The level trio is republished from a snapshot taken when no probe is in the
  // middle of a debounce window.
  logic [6:0] hist[$];
  logic [6:0] m_deb;
  logic [2:0] m_pub;
  bit         m_pending;
  int         m_edges;
  logic       m_valid;
  logic       m_chg;
  logic [6:0] m_out;
  logic [6:0] m_out_prev;

  task automatic model_reset();
    hist.delete();
    m_deb      = '0;
    m_pub      = '0;
    m_pending  = 0;
    m_edges    = 0;
    m_valid    = 1'b0;
    m_chg      = 1'b0;
    m_out      = '0;
    m_out_prev = '0;
  endtask

  // raw value sampled d edges ago; before reset release the synchronizer held 0
  function automatic logic [6:0] sample(input int d);
    if (hist.size() > d) return hist[hist.size() - 1 - d];
    return '0;
  endfunction

  task automatic model_step(input logic [6:0] s);
    logic [6:0] sync_now;
    logic [6:0] busy_pre;
    logic [6:0] smp;
    int         run;
    bit         same;
    hist.push_back(s);
    if (hist.size() > 16) void'(hist.pop_front());
    sync_now = sample(2);
    busy_pre = sample(3) ^ m_deb;
    m_chg      = (m_out != m_out_prev);
    m_out_prev = m_out;
    if (m_pending) begin
      if (busy_pre[6:4] == 3'b000) begin
        m_pub     = m_deb[6:4];
        m_pending = 0;
      end
    end else if (busy_pre[6:4] != 3'b000 || m_deb[6:4] != m_pub) begin
      m_pending = 1;
    end
    for (int ch = 0; ch < 7; ch++) begin
      if (sync_now[ch] != m_deb[ch]) begin
        run  = 0;
        same = 1;
        for (int d = 2; d < 2 + DEB; d++) begin
          smp = sample(d);
          if (same && smp[ch] == sync_now[ch]) run++;
          else same = 0;
        end
        if (run == DEB) m_deb[ch] = sync_now[ch];
      end
    end
    m_edges++;
    m_valid = (m_edges >= DEB + 2);
    m_out   = {m_pub, m_deb[3:0]};
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step(raw);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    raw = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dut_out, bus.valid, bus.chg} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 000000000", {dut_out, bus.valid, bus.chg});
    end
    rst = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (bus.valid !== (j >= 6)) begin
        errors++;
        $display("FAIL startup_valid cycle %0d got %b want %b", j, bus.valid, (j >= 6));
      end
      checks++;
      if (dut_out !== 7'b0 || bus.chg !== 1'b0) begin
        errors++;
        $display("FAIL startup_quiet cycle %0d got out=%b chg=%b want 0", j, dut_out, bus.chg);
      end
    end
  endtask

  task automatic test_switch_latency();
    raw[3] = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (bus.Us !== (j >= 6)) begin
        errors++;
        $display("FAIL us_latency cycle %0d got %b want %b", j, bus.Us, (j >= 6));
      end
      checks++;
      if (bus.chg !== (j == 7)) begin
        errors++;
        $display("FAIL us_chg cycle %0d got %b want %b", j, bus.chg, (j == 7));
      end
    end
  endtask

  task automatic test_glitch();
    raw[2] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 3) raw[2] = 1'b0;
      checks++;
      if (bus.Ua !== 1'b0 || bus.chg !== 1'b0) begin
        errors++;
        $display("FAIL ua_glitch cycle %0d got Ua=%b chg=%b want 0 0", j, bus.Ua, bus.chg);
      end
    end
  endtask

  task automatic test_level_group();
    int pulses = 0;
    raw[4] = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      tick();
      if (j == 2) raw[5] = 1'b1;
      if (bus.chg === 1'b1) pulses++;
      checks++;
      if (dut_lvl !== ((j >= 9) ? 3'b011 : 3'b000)) begin
        errors++;
        $display("FAIL level_atomic cycle %0d got %b want %b", j, dut_lvl,
                 (j >= 9) ? 3'b011 : 3'b000);
      end
      checks++;
      if (dut_out !== m_out) begin
        errors++;
        $display("FAIL level_model cycle %0d got %b want %b", j, dut_out, m_out);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL level_chg_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_bounce();
    for (int seg = 0; seg < 20; seg++) begin
      raw[6] = (seg % 2 == 0);
      repeat (2) begin
        tick();
        checks++;
        if (dut_lvl !== 3'b011 || bus.chg !== 1'b0) begin
          errors++;
          $display("FAIL bounce_hold seg %0d got lvl=%b chg=%b want 011 0", seg, dut_lvl, bus.chg);
        end
      end
    end
    raw[6] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      checks++;
      if (dut_lvl !== ((j >= 7) ? 3'b111 : 3'b011)) begin
        errors++;
        $display("FAIL bounce_settle cycle %0d got %b want %b", j, dut_lvl,
                 (j >= 7) ? 3'b111 : 3'b011);
      end
      checks++;
      if (bus.chg !== (j == 8)) begin
        errors++;
        $display("FAIL bounce_chg cycle %0d got %b want %b", j, bus.chg, (j == 8));
      end
    end
  endtask

  task automatic test_reset_mid();
    raw[1] = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({dut_out, bus.valid, bus.chg} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset got %b want 000000000", {dut_out, bus.valid, bus.chg});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({dut_out, bus.valid, bus.chg} !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold got %b want 000000000", {dut_out, bus.valid, bus.chg});
    end
    rst = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      tick();
      checks++;
      if (bus.T !== (j >= 6) || bus.Us !== (j >= 6)) begin
        errors++;
        $display("FAIL t_after_reset cycle %0d got T=%b Us=%b want %b", j, bus.T, bus.Us, (j >= 6));
      end
      checks++;
      if (dut_lvl !== ((j >= 7) ? 3'b111 : 3'b000)) begin
        errors++;
        $display("FAIL lvl_after_reset cycle %0d got %b want %b", j, dut_lvl,
                 (j >= 7) ? 3'b111 : 3'b000);
      end
      checks++;
      if (bus.valid !== (j >= 6)) begin
        errors++;
        $display("FAIL valid_after_reset cycle %0d got %b want %b", j, bus.valid, (j >= 6));
      end
    end
  endtask

  task automatic test_random();
    int n = 0;
    while (n < 900) begin
      int hold;
      raw  = raw ^ 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        tick();
        n++;
        checks++;
        if (dut_out !== m_out) begin
          errors++;
          $display("FAIL rand_out cycle %0d got %b want %b", n, dut_out, m_out);
        end
        checks++;
        if (bus.chg !== m_chg || bus.valid !== m_valid) begin
          errors++;
          $display("FAIL rand_flags cycle %0d got chg=%b valid=%b want chg=%b valid=%b",
                   n, bus.chg, bus.valid, m_chg, m_valid);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_switch_latency();
    test_glitch();
    test_level_group();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
